// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - in-order fixed-latency memory responder with a credit-limited response FIFO
// Optional feature: define MEM_RESPONDER_MISALIGN_EN to flag odd byte addresses with resp_err.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_write,
  output logic        resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [15:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               accept, pop, push, req_err, mem_we;

  logic [LATENCY-1:0] pv_q, pv_d, pw_q, pw_d;
  logic [15:0]        pd_q [LATENCY];
  logic [15:0]        pd_d [LATENCY];
  logic [PW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic [OW-1:0]      outs_q, outs_d, fcnt_q, fcnt_d;
  logic [15:0]        fd_q [DEPTH];
  logic [15:0]        fd_d [DEPTH];
  logic [DEPTH-1:0]   fw_q, fw_d;
`ifdef MEM_RESPONDER_MISALIGN_EN
  logic [LATENCY-1:0] pe_q, pe_d;
  logic [DEPTH-1:0]   fe_q, fe_d;
  logic               unused_addr_bits;
  assign unused_addr_bits = ^req_addr[15:ADDR_W+1];
`else
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[15:ADDR_W+1], req_addr[0]};
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both the pipeline and the FIFO, so a pipeline exit always finds room.
  assign req_ready  = (outs_q < DEPTH_C);
  assign resp_valid = (fcnt_q != '0);
  assign resp_data  = resp_valid ? fd_q[rptr_q] : 16'h0;
  assign resp_write = resp_valid & fw_q[rptr_q];
`ifdef MEM_RESPONDER_MISALIGN_EN
  assign resp_err   = resp_valid & fe_q[rptr_q];
`else
  assign resp_err   = 1'b0;
`endif

  always_comb begin
    accept = req_valid & req_ready;
    pop    = resp_valid & resp_ready;
    push   = pv_q[LATENCY-1];
    idx    = req_addr[ADDR_W:1];
`ifdef MEM_RESPONDER_MISALIGN_EN
    req_err = req_addr[0];
`else
    req_err = 1'b0;
`endif
    // A write presented while reset is held must not reach the array.
    mem_we = accept & req_write & ~req_err & ~rst;

    pv_d = pv_q;
    pw_d = pw_q;
    pd_d = pd_q;
`ifdef MEM_RESPONDER_MISALIGN_EN
    pe_d = pe_q;
`endif
    for (int i = LATENCY - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pw_d[i] = pw_q[i-1];
      pd_d[i] = pd_q[i-1];
`ifdef MEM_RESPONDER_MISALIGN_EN
      pe_d[i] = pe_q[i-1];
`endif
    end
    pv_d[0] = accept;
    pw_d[0] = req_write;
    pd_d[0] = (req_write | req_err) ? 16'h0 : mem[idx];
`ifdef MEM_RESPONDER_MISALIGN_EN
    pe_d[0] = req_err;
`endif

    fd_d   = fd_q;
    fw_d   = fw_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
`ifdef MEM_RESPONDER_MISALIGN_EN
    fe_d   = fe_q;
`endif
    if (push) begin
      fd_d[wptr_q] = pd_q[LATENCY-1];
      fw_d[wptr_q] = pw_q[LATENCY-1];
`ifdef MEM_RESPONDER_MISALIGN_EN
      fe_d[wptr_q] = pe_q[LATENCY-1];
`endif
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);

    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    case ({accept, pop})
      2'b10:   outs_d = outs_q + 1'b1;
      2'b01:   outs_d = outs_q - 1'b1;
      default: outs_d = outs_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q   <= '0;
      pw_q   <= '0;
      fw_q   <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      outs_q <= '0;
      fcnt_q <= '0;
`ifdef MEM_RESPONDER_MISALIGN_EN
      pe_q   <= '0;
      fe_q   <= '0;
`endif
    end else begin
      pv_q   <= pv_d;
      pw_q   <= pw_d;
      fw_q   <= fw_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      outs_q <= outs_d;
      fcnt_q <= fcnt_d;
`ifdef MEM_RESPONDER_MISALIGN_EN
      pe_q   <= pe_d;
      fe_q   <= fe_d;
`endif
    end
  end

  // Data payloads are qualified by the valid bits and count, so they need no reset.
  always_ff @(posedge clk) begin
    pd_q <= pd_d;
    fd_q <= fd_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= req_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with a timestamped queue reference model
module tb_mem_responder;

  localparam int LAT   = 4;
  localparam int DEP   = 4;
  localparam int WORDS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        resp_write;
  logic        resp_err;

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [WORDS];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  mem_responder #(.ADDR_W(10), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_write(resp_write), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted request yields one response, due LAT edges after acceptance.
  function automatic exp_t model(input logic wr, input logic [15:0] a, input logic [15:0] wd, input int acc);
    exp_t e;
    int   w;
    w      = int'(a[5:1]);
    e.acc  = acc;
    e.wr   = wr;
    e.data = 16'h0;
    e.err  = 1'b0;
`ifdef MEM_RESPONDER_MISALIGN_EN
    if (a[0]) begin
      e.err = 1'b1;
      return e;
    end
`endif
    if (wr) ref_mem[w] = wd;
    else    e.data = ref_mem[w];
    return e;
  endfunction

  task automatic step(output bit acc);
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      chk("req_ready", req_ready, sb.size() < DEP);
      if (req_valid && req_ready) begin
        acc = 1'b1;
        sb.push_back(model(req_write, req_addr, req_wdata, cyc + 1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
    bit acc;
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 200);
    chk("issue_accepted", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    while (sb.size() > 0 && n < 300) begin
      idle(1);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor runs after the stimulus sample so queue size equals the DUT's outstanding count.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("resp_valid", resp_valid, (sb.size() > 0 && sb[0].acc + LAT <= cyc));
      if (resp_valid && resp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_write", resp_write, e.wr);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", resp_err, e.err);
      end
    end
  end

  initial begin
    bit acc;
    int k;

    idle(2);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_write", resp_write, 0);
    chk("rst_resp_err", resp_err, 0);
    rst = 1'b0;

    resp_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) issue(1'b1, 16'(i * 2), 16'($urandom));
    drain();

    issue(1'b1, 16'h0010, 16'h1234);
    issue(1'b0, 16'h0010, 16'h0);
    drain();

    issue(1'b1, 16'h0000, 16'hAAAA);
    issue(1'b1, 16'h0002, 16'hBBBB);
    issue(1'b1, 16'h0004, 16'hCCCC);
    drain();
    issue(1'b0, 16'h0000, 16'h0);
    issue(1'b0, 16'h0002, 16'h0);
    issue(1'b0, 16'h0004, 16'h0);
    drain();

    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    k = 0;
    repeat (12) begin
      req_addr = 16'(k * 2);
      step(acc);
      if (acc) k++;
    end
    chk("accepts_while_full", k, 4);
    resp_ready = 1'b1;
    step(acc);
    chk("no_accept_on_pop_cycle", acc, 0);
    resp_ready = 1'b0;
    step(acc);
    chk("fifth_accept", acc, 1);
    drain();

    resp_ready = 1'b0;
    issue(1'b0, 16'h0002, 16'h0);
    idle(5);
    issue(1'b0, 16'h0004, 16'h0);
    issue(1'b0, 16'h0006, 16'h0);
    rst = 1'b1;
    #1;
    chk("rst_async_resp_valid", resp_valid, 0);
    chk("rst_async_req_ready", req_ready, 1);
    sb.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0006; req_wdata = 16'hDEAD;
    idle(2);
    req_valid = 1'b0;
    rst = 1'b0;
    resp_ready = 1'b1;
    issue(1'b0, 16'h0006, 16'h0);
    issue(1'b0, 16'h0004, 16'h0);
    drain();

    issue(1'b1, 16'h0021, 16'h5555);
    issue(1'b0, 16'h0020, 16'h0);
    drain();

    for (int i = 0; i < 600; i++) begin
      req_valid  = 1'($urandom);
      req_write  = 1'($urandom);
      req_addr   = 16'($urandom_range(0, 63));
      req_wdata  = 16'($urandom);
      resp_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      step(acc);
    end
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
